// File: rtl/spi_memory_slave.sv
// SPI peripheral core: 128 x 8 register memory behind an 8-bit command
// (7-bit address MSB-first, then R/W) followed by one 8-bit data phase.
module spi_memory_slave #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_cond,
  input  logic mosi_cond,
  input  logic sclk_posedge,
  input  logic sclk_negedge,
  output logic miso_out,
  output logic miso_oe,
  output logic xfer_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CMD_LAST  = 4'(ADDR_WIDTH);
  localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GET_CMD    = 3'd1,
    ST_READ_LOAD  = 3'd2,
    ST_READ_SHIFT = 3'd3,
    ST_WRITE_GET  = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sh;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rw;
  logic                  r_miso_out;
  logic                  r_miso_oe;
  logic                  r_xfer_done;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_sh_in;

  assign w_rd_data = r_mem[r_addr];
  assign w_sh_in   = {r_sh[DATA_WIDTH-2:0], mosi_cond};

  assign miso_out  = r_miso_out;
  assign miso_oe   = r_miso_oe;
  assign xfer_done = r_xfer_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_miso_out  <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_xfer_done <= 1'b0;
      // NOTE: the memory is a flop array that must read back zero after reset,
      // so every word is cleared here rather than left to power-up contents.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_xfer_done <= 1'b0;
      if (r_state != ST_IDLE && cs_cond) begin
        // CS release outranks any edge pulse sampled in the same cycle.
        r_state    <= ST_IDLE;
        r_miso_out <= 1'b0;
        r_miso_oe  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_miso_out <= 1'b0;
            r_miso_oe  <= 1'b0;
            if (!cs_cond) begin
              r_state <= ST_GET_CMD;
              r_sh    <= '0;
              r_cnt   <= '0;
            end
          end
          ST_GET_CMD: begin
            if (sclk_posedge) begin
              r_sh <= w_sh_in;
              if (r_cnt == CMD_LAST) begin
                r_addr  <= r_sh[ADDR_WIDTH-1:0];
                r_rw    <= mosi_cond;
                r_cnt   <= '0;
                r_state <= mosi_cond ? ST_READ_LOAD : ST_WRITE_GET;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          ST_READ_LOAD: begin
            r_sh      <= w_rd_data;
            r_miso_oe <= 1'b1;
            r_state   <= ST_READ_SHIFT;
          end
          ST_READ_SHIFT: begin
            if (sclk_negedge) begin
              r_miso_out <= r_sh[DATA_WIDTH-1];
              r_sh       <= {r_sh[DATA_WIDTH-2:0], 1'b0};
              if (r_cnt == DATA_LAST) begin
                r_cnt       <= '0;
                r_miso_oe   <= 1'b0;
                r_xfer_done <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          ST_WRITE_GET: begin
            if (sclk_posedge) begin
              r_sh <= w_sh_in;
              if (r_cnt == DATA_LAST) begin
                // The latched R/W bit gates the write port as a second guard.
                if (!r_rw) r_mem[r_addr] <= w_sh_in;
                r_cnt       <= '0;
                r_xfer_done <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          ST_DONE: begin
            r_miso_oe <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_memory_slave.sv
// Directed bench for spi_memory_slave: write, read, abort, reset, back-to-back.
module tb_spi_memory_slave;

  logic clk = 1'b0;
  logic reset;
  logic cs_cond;
  logic mosi_cond;
  logic sclk_posedge;
  logic sclk_negedge;
  logic miso_out;
  logic miso_oe;
  logic xfer_done;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int oe_cnt   = 0;
  int d0;
  int o0;

  spi_memory_slave dut (
    .clk          (clk),
    .reset        (reset),
    .cs_cond      (cs_cond),
    .mosi_cond    (mosi_cond),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .miso_out     (miso_out),
    .miso_oe      (miso_oe),
    .xfer_done    (xfer_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (xfer_done === 1'b1) done_cnt++;
    if (miso_oe === 1'b1) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pos_pulse();
    sclk_posedge = 1'b1;
    tick();
    sclk_posedge = 1'b0;
  endtask

  task automatic neg_pulse();
    sclk_negedge = 1'b1;
    tick();
    sclk_negedge = 1'b0;
  endtask

  task automatic begin_frame();
    cs_cond = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    tick();
    cs_cond = 1'b1;
    tick();
  endtask

  // Command bits; the falling edges between bits must be ignored.
  task automatic send_cmd(input logic [7:0] cmd);
    for (int i = 7; i >= 0; i--) begin
      if (i != 7) begin
        tick(); tick(); neg_pulse();
      end
      mosi_cond = cmd[i];
      tick(); tick();
      pos_pulse();
    end
  endtask

  task automatic write_data(input logic [7:0] d, input int nbits, input bit cs_on_last);
    for (int i = 0; i < nbits; i++) begin
      tick(); tick(); neg_pulse();
      mosi_cond = d[7-i];
      tick(); tick();
      if (cs_on_last && i == nbits - 1) cs_cond = 1'b1;
      pos_pulse();
    end
  endtask

  task automatic read_data(input string tag, input logic [7:0] exp, input int nbits);
    check({tag, " oe_in_load"}, miso_oe, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      tick();
      if (i == 0) check({tag, " oe_rise"}, miso_oe, 32'd1);
      tick();
      neg_pulse();
      check($sformatf("%s bit%0d", tag, 7 - i), miso_out, exp[7-i]);
      if (i == 7) begin
        check({tag, " done_pulse"}, xfer_done, 32'd1);
        check({tag, " oe_off_done"}, miso_oe, 32'd0);
      end else begin
        check({tag, " oe_held"}, miso_oe, 32'd1);
        tick(); tick();
        pos_pulse();
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    cs_cond      = 1'b1;
    mosi_cond    = 1'b0;
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst miso_out", miso_out, 32'd0);
    check("rst miso_oe", miso_oe, 32'd0);
    check("rst xfer_done", xfer_done, 32'd0);
    check("rst state", dut.r_state, 32'd0);
    check("rst mem12", dut.r_mem[7'h12], 32'h00);

    // Write 0xA5 to 0x12
    d0 = done_cnt; o0 = oe_cnt;
    begin_frame();
    send_cmd(8'h24);
    write_data(8'hA5, 8, 1'b0);
    check("wr done_pulse", xfer_done, 32'd1);
    check("wr mem12", dut.r_mem[7'h12], 32'hA5);
    tick();
    check("wr done_once", xfer_done, 32'd0);
    end_frame();
    check("wr done_count", done_cnt - d0, 32'd1);
    check("wr oe_never", oe_cnt - o0, 32'd0);

    // Read 0x12
    d0 = done_cnt;
    begin_frame();
    send_cmd(8'h25);
    read_data("rd12", 8'hA5, 8);
    end_frame();
    check("rd12 done_count", done_cnt - d0, 32'd1);
    check("rd12 idle", dut.r_state, 32'd0);

    // Abort after 12 posedges of a write to 0x05
    d0 = done_cnt;
    begin_frame();
    send_cmd(8'h0A);
    write_data(8'hFF, 4, 1'b0);
    tick();
    cs_cond = 1'b1;
    tick();
    check("abort12 idle", dut.r_state, 32'd0);
    check("abort12 xfer_done", xfer_done, 32'd0);
    tick();
    check("abort12 mem05", dut.r_mem[7'h05], 32'h00);

    // CS rise coincident with the 16th posedge
    begin_frame();
    send_cmd(8'h0A);
    write_data(8'hFF, 8, 1'b1);
    check("abort16 idle", dut.r_state, 32'd0);
    check("abort16 xfer_done", xfer_done, 32'd0);
    check("abort16 mem05", dut.r_mem[7'h05], 32'h00);
    tick();
    check("abort16 xfer_late", xfer_done, 32'd0);
    check("abort done_count", done_cnt - d0, 32'd0);

    // Reset during a read's data phase
    begin_frame();
    send_cmd(8'h25);
    read_data("rstrd", 8'hA5, 3);
    tick();
    reset   = 1'b1;
    cs_cond = 1'b1;
    tick();
    reset = 1'b0;
    check("rstrd miso_oe", miso_oe, 32'd0);
    check("rstrd miso_out", miso_out, 32'd0);
    check("rstrd idle", dut.r_state, 32'd0);
    d0 = done_cnt;
    begin_frame();
    send_cmd(8'h25);
    read_data("rdclr", 8'h00, 8);
    end_frame();
    check("rdclr done_count", done_cnt - d0, 32'd1);

    // Read unwritten 0x7F, then extra SCLK cycles
    d0 = done_cnt;
    begin_frame();
    send_cmd(8'hFF);
    read_data("rd7f", 8'h00, 8);
    repeat (4) begin
      tick(); tick(); pos_pulse();
      tick(); tick(); neg_pulse();
      check("rd7f extra miso_out", miso_out, 32'd0);
      check("rd7f extra miso_oe", miso_oe, 32'd0);
      check("rd7f extra xfer_done", xfer_done, 32'd0);
    end
    end_frame();
    check("rd7f done_count", done_cnt - d0, 32'd1);

    // Back-to-back with CS high for a single cycle
    d0 = done_cnt;
    begin_frame();
    send_cmd(8'h02);
    write_data(8'h3C, 8, 1'b0);
    tick();
    cs_cond = 1'b1;
    tick();
    begin_frame();
    send_cmd(8'h03);
    read_data("b2b", 8'h3C, 8);
    end_frame();
    check("b2b mem01", dut.r_mem[7'h01], 32'h3C);
    check("b2b done_count", done_cnt - d0, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_memory_slave.md
# spi_memory_slave

SPI peripheral core implementing a 128-byte register memory. It sits directly downstream of three input-conditioner instances: it consumes their conditioned chip-select and MOSI levels and the one-cycle SCLK edge pulses, and produces MISO plus its output enable. Each CS-framed transaction is 8 command bits (7-bit address MSB-first, then R/W), followed by 8 data bits written in on MOSI or read out on MISO.

## Interface
- ADDR_WIDTH, 7, address bits; memory depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8, data bits per word and per data phase.

- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cs_cond  input  1  conditioned chip select, active low.
- mosi_cond  input  1  conditioned MOSI level.
- sclk_posedge  input  1  one-cycle pulse on conditioned SCLK rising edge.
- sclk_negedge  input  1  one-cycle pulse on conditioned SCLK falling edge.
- miso_out  output  1  registered MISO data.
- miso_oe  output  1  MISO tri-state enable; high only while driving read data.
- xfer_done  output  1  one-cycle pulse when a read or write transaction completes.

## Operation
- Internal state:
  - 8-bit shift register `sh`.
  - 4-bit bit counter `cnt`.
  - Address register `addr` and R/W register `rw`.
  - Memory `mem[0:2^ADDR_WIDTH-1]`, read combinationally.
- States:
  - IDLE: outputs low. If cs_cond==0, go to GET_CMD with sh=0 and cnt=0.
  - GET_CMD: on each sclk_posedge, sh<={sh[6:0],mosi_cond} and cnt++.
    - On the 8th posedge (cnt==7 before increment): addr<=sh[6:0], rw<=mosi_cond, cnt<=0.
    - Go to READ_LOAD if mosi_cond==1, else WRITE_GET.
  - READ_LOAD: one cycle. sh<=mem[addr]. Go to READ_SHIFT.
  - READ_SHIFT: miso_oe=1.
    - On each sclk_negedge: miso_out<=sh[7], sh<=sh<<1, cnt++.
    - After the 8th negedge, go to DONE and pulse xfer_done.
  - WRITE_GET: on each sclk_posedge, sh<={sh[6:0],mosi_cond} and cnt++.
    - On the 8th posedge, in the same cycle: mem[addr]<={sh[6:0],mosi_cond}, xfer_done pulses next cycle, go to DONE.
  - DONE: ignores all edges, miso_oe=0. Go to IDLE when cs_cond==1.
- Abort: cs_cond==1 in any non-IDLE state forces IDLE next cycle.
  - Abort has priority over a same-cycle edge pulse: no write, no xfer_done.
  - miso_oe drops next cycle; miso_out<=0.
- Edge filtering:
  - sclk_negedge is ignored in GET_CMD and WRITE_GET.
  - sclk_posedge is ignored in READ_LOAD and READ_SHIFT.
  - A negedge arriving during READ_LOAD is dropped.
- Memory is not read-modify-write; a write replaces the full word.
- Addressing never wraps; one word per CS frame. Extra SCLK edges after DONE are ignored.

## Timing
- Reset (synchronous, one clk edge):
  - State=IDLE.
  - miso_out=0, miso_oe=0, xfer_done=0.
  - sh=0, cnt=0, addr=0, rw=0.
  - Every mem word=0.
- Reset has priority over all other events, including mid-transaction; miso_oe is low the cycle after reset is sampled.
- CS low to GET_CMD: 1 cycle.
- 8th command posedge to READ_SHIFT: 2 cycles (addr/rw latch, then READ_LOAD). miso_oe is high from the 2nd cycle.
- Read data: miso_out changes the cycle after each sclk_negedge pulse, MSB first.
  - The master samples on the following SCLK rise.
  - The first data negedge must arrive ≥2 clk after the 8th command posedge.
  - This is guaranteed, since conditioner debounce delay ≥3 clk per half period.
- Write: mem is updated on the clk edge that samples the 8th data posedge pulse; xfer_done is high the next cycle.
- Read: xfer_done is high the cycle after the 8th data negedge is sampled.
- CS high to IDLE: 1 cycle.
- Back-to-back frames: CS may be high for a single clk cycle.

## Test plan
- Write frame: command byte 0x24 (addr 0x12, W), then data 0xA5.
  - mem[0x12]=0xA5.
  - xfer_done pulses once, the cycle after the 16th posedge.
  - miso_oe stays 0 throughout.
- Read frame 0x25 after the write above:
  - miso_out after successive negedges = 1,0,1,0,0,1,0,1.
  - miso_oe is high from 2 cycles after the 8th posedge until DONE.
  - xfer_done pulses after the 8th negedge.
- Abort: CS rises after 12 posedges of a write to addr 0x05 with data 0xFF.
  - mem[0x05] is unchanged (0x00).
  - No xfer_done; IDLE next cycle.
  - A CS rise coinciding with the 16th posedge also causes no write.
- Reset is asserted one cycle mid-way through a read's data phase.
  - Next cycle: miso_oe=0, miso_out=0, state IDLE.
  - A subsequent read of 0x12 returns 0x00, because memory is cleared.
- Read of unwritten address 0x7F (command 0xFF):
  - Shifts out 0x00.
  - 4 extra SCLK cycles before CS rises produce no further miso_out change and no extra xfer_done.
- Back-to-back frames with CS high for 1 cycle: write 0x3C to 0x01, then read 0x01.
  - Returns 0x3C.
  - Exactly two xfer_done pulses.
